// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared constants for the EX-stage forwarding/hazard controller:
// register-address width, operand-mux select encodings and FSM states.
package fwd_hazard_ctrl_pkg;

    localparam int REG_AW = 4;

    localparam logic [1:0] SEL_BUFF2 = 2'b11;
    localparam logic [1:0] SEL_ALU   = 2'b01;
    localparam logic [1:0] SEL_M5    = 2'b00;

    typedef enum logic {
        IDLE     = 1'b0,
        LU_STALL = 1'b1
    } state_t;

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// Decode-side bundle into the forwarding/hazard controller and its control outputs.
interface fwd_hazard_ctrl_if
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = fwd_hazard_ctrl_pkg::REG_AW,
    parameter int CNT_W  = 16
);
    logic              in_hold;
    logic              in_flush;
    logic              in_dec_valid;
    logic [REG_AW-1:0] in_dec_rs1;
    logic [REG_AW-1:0] in_dec_rs2;
    logic              in_dec_use1;
    logic              in_dec_use2;
    logic [REG_AW-1:0] in_dec_rd;
    logic              in_dec_we;
    logic              in_dec_load;
    logic [1:0]        out_cntrl_m2;
    logic [1:0]        out_cntrl_m3;
    logic              out_stall;
    logic              out_bubble;
    logic [CNT_W-1:0]  out_stall_cnt;

    modport master (
        output in_hold, in_flush, in_dec_valid, in_dec_rs1, in_dec_rs2,
               in_dec_use1, in_dec_use2, in_dec_rd, in_dec_we, in_dec_load,
        input  out_cntrl_m2, out_cntrl_m3, out_stall, out_bubble, out_stall_cnt
    );

    modport slave (
        input  in_hold, in_flush, in_dec_valid, in_dec_rs1, in_dec_rs2,
               in_dec_use1, in_dec_use2, in_dec_rd, in_dec_we, in_dec_load,
        output out_cntrl_m2, out_cntrl_m3, out_stall, out_bubble, out_stall_cnt
    );

endinterface

// File: rtl/fwd_hazard_ctrl_match_unit.sv
// Compares one source operand against the EX and MEM destinations and picks
// the forwarding source; the EX (youngest) producer has priority.
module fwd_match_unit
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW  = fwd_hazard_ctrl_pkg::REG_AW,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic              use_rs,
    input  logic [REG_AW-1:0] rs,
    input  logic              ex_vld,
    input  logic              ex_we,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mem_vld,
    input  logic              mem_we,
    input  logic [REG_AW-1:0] mem_rd,
    output logic              ex_match,
    output logic [1:0]        sel
);

    logic is_r0;
    logic mem_match;

    assign is_r0     = R0_ZERO && (rs == '0);
    assign ex_match  = use_rs & ex_vld & ex_we & (rs == ex_rd) & ~is_r0;
    assign mem_match = use_rs & mem_vld & mem_we & (rs == mem_rd) & ~is_r0;

    always_comb begin
        sel = SEL_BUFF2;
        if (ex_match)
            sel = SEL_ALU;
        else if (mem_match)
            sel = SEL_M5;
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the EX-stage operand muxes m2/m3.
// Tracks buff2/buff3 destinations and registers the selects with the issuing edge.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW  = fwd_hazard_ctrl_pkg::REG_AW,
    parameter bit R0_ZERO = 1'b1,
    parameter int CNT_W   = 16
) (
    input logic              clk,
    input logic              rst,
    fwd_hazard_ctrl_if.slave bus
);

    state_t            state, next_state;
    logic              ex_vld, ex_we, ex_load, mem_vld, mem_we;
    logic [REG_AW-1:0] ex_rd, mem_rd;
    logic [1:0]        sel_m2, sel_m3, sel1, sel2;
    logic              match1, match2, hazard, stall, issue;
    logic [CNT_W-1:0]  cnt;

    fwd_match_unit #(.REG_AW(REG_AW), .R0_ZERO(R0_ZERO)) u_match1 (
        .use_rs(bus.in_dec_use1), .rs(bus.in_dec_rs1),
        .ex_vld(ex_vld), .ex_we(ex_we), .ex_rd(ex_rd),
        .mem_vld(mem_vld), .mem_we(mem_we), .mem_rd(mem_rd),
        .ex_match(match1), .sel(sel1)
    );

    fwd_match_unit #(.REG_AW(REG_AW), .R0_ZERO(R0_ZERO)) u_match2 (
        .use_rs(bus.in_dec_use2), .rs(bus.in_dec_rs2),
        .ex_vld(ex_vld), .ex_we(ex_we), .ex_rd(ex_rd),
        .mem_vld(mem_vld), .mem_we(mem_we), .mem_rd(mem_rd),
        .ex_match(match2), .sel(sel2)
    );

    // The hazard cycle itself is the single stall; LU_STALL lets the held
    // instruction re-issue with the load now visible in MEM.
    always_comb begin
        next_state = state;
        hazard     = 1'b0;
        case (state)
            IDLE: begin
                hazard = bus.in_dec_valid & ex_vld & ex_load & (match1 | match2);
                if (hazard & ~bus.in_hold & ~bus.in_flush)
                    next_state = LU_STALL;
            end
            LU_STALL: begin
                if (~bus.in_hold)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign stall = hazard & ~bus.in_flush;
    assign issue = bus.in_dec_valid & ~stall & ~bus.in_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ex_vld  <= 1'b0;
            ex_we   <= 1'b0;
            ex_load <= 1'b0;
            ex_rd   <= '0;
            mem_vld <= 1'b0;
            mem_we  <= 1'b0;
            mem_rd  <= '0;
            sel_m2  <= SEL_BUFF2;
            sel_m3  <= SEL_BUFF2;
            cnt     <= '0;
        end else if (~bus.in_hold) begin
            state   <= next_state;
            mem_vld <= ex_vld;
            mem_we  <= ex_we;
            mem_rd  <= ex_rd;
            ex_vld  <= issue;
            ex_we   <= issue & bus.in_dec_we;
            ex_load <= issue & bus.in_dec_load;
            ex_rd   <= issue ? bus.in_dec_rd : '0;
            sel_m2  <= issue ? sel1 : SEL_BUFF2;
            sel_m3  <= issue ? sel2 : SEL_BUFF2;
            if (stall && (cnt != '1))
                cnt <= cnt + 1'b1;
        end
    end

    assign bus.out_cntrl_m2  = sel_m2;
    assign bus.out_cntrl_m3  = sel_m3;
    assign bus.out_stall     = stall;
    assign bus.out_bubble    = stall;
    assign bus.out_stall_cnt = cnt;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: stimulus queues expected outputs per cycle,
// a monitor pops and compares them on the falling edge (or right after an async reset).
`timescale 1ns/1ps
module tb_fwd_hazard_ctrl;

    typedef struct {
        int         cyc;
        string      name;
        logic [1:0] m2;
        logic [1:0] m3;
        logic       stall;
        int         cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t q[$];

    fwd_hazard_ctrl_if #(.REG_AW(4), .CNT_W(8)) bus ();

    fwd_hazard_ctrl #(.REG_AW(4), .R0_ZERO(1'b1), .CNT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dec(input int rd, input bit we, input bit ld,
                       input int rs1, input bit u1, input int rs2, input bit u2);
        bus.in_dec_valid = 1'b1;
        bus.in_dec_rd    = 4'(rd);
        bus.in_dec_we    = we;
        bus.in_dec_load  = ld;
        bus.in_dec_rs1   = 4'(rs1);
        bus.in_dec_use1  = u1;
        bus.in_dec_rs2   = 4'(rs2);
        bus.in_dec_use2  = u2;
    endtask

    task automatic nop();
        dec(0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        bus.in_dec_valid = 1'b0;
    endtask

    task automatic expect_now(input string nm, input logic [1:0] m2, input logic [1:0] m3,
                              input logic st, input int cnt);
        exp_t e;
        e.cyc = cyc; e.name = nm; e.m2 = m2; e.m3 = m3; e.stall = st; e.cnt = cnt;
        q.push_back(e);
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or posedge rst);
            #1;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                n_vec++;
                if (e.cyc != cyc) begin
                    n_err++;
                    $display("FAIL %s not sampled in cycle %0d (now %0d)", e.name, e.cyc, cyc);
                end else if ({bus.out_cntrl_m2, bus.out_cntrl_m3, bus.out_stall, bus.out_bubble}
                             !== {e.m2, e.m3, e.stall, e.stall} ||
                             bus.out_stall_cnt !== 8'(e.cnt)) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d got m2=%b m3=%b stall=%b bubble=%b cnt=%0d want m2=%b m3=%b stall=%b bubble=%b cnt=%0d",
                             e.name, cyc, bus.out_cntrl_m2, bus.out_cntrl_m3, bus.out_stall,
                             bus.out_bubble, bus.out_stall_cnt, e.m2, e.m3, e.stall, e.stall, e.cnt);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.in_hold = 1'b0;
        bus.in_flush = 1'b0;
        nop();
        repeat (2) @(posedge clk);
        #1;
        expect_now("reset", 2'b11, 2'b11, 1'b0, 0); tick();
        rst = 1'b0;

        // ADD r3 ; SUB r5 = r3 + r1
        dec(3, 1, 0, 1, 1, 2, 1); expect_now("t1_add",  2'b11, 2'b11, 1'b0, 0); tick();
        dec(5, 1, 0, 3, 1, 1, 1); expect_now("t1_sub",  2'b11, 2'b11, 1'b0, 0); tick();
        nop();                    expect_now("t1_sel",  2'b01, 2'b11, 1'b0, 0); tick();

        // ADD r3 ; NOP ; OR r6 = r2, r3
        dec(3, 1, 0, 1, 1, 2, 1); expect_now("t2_add",  2'b11, 2'b11, 1'b0, 0); tick();
        nop();                    expect_now("t2_nop",  2'b11, 2'b11, 1'b0, 0); tick();
        dec(6, 1, 0, 2, 1, 3, 1); expect_now("t2_or",   2'b11, 2'b11, 1'b0, 0); tick();
        nop();                    expect_now("t2_sel",  2'b11, 2'b00, 1'b0, 0); tick();

        // LD r4 ; ADD r7 = r4 + r4
        dec(4, 1, 1, 1, 1, 0, 0); expect_now("t3_ld",    2'b11, 2'b11, 1'b0, 0); tick();
        dec(7, 1, 0, 4, 1, 4, 1); expect_now("t3_stall", 2'b11, 2'b11, 1'b1, 0); tick();
        expect_now("t3_reissue", 2'b11, 2'b11, 1'b0, 1); tick();
        nop();                    expect_now("t3_sel",   2'b00, 2'b00, 1'b0, 1); tick();

        // r0 write then read: never forwarded
        dec(0, 1, 0, 1, 1, 0, 0); expect_now("t4_w0",   2'b11, 2'b11, 1'b0, 1); tick();
        dec(8, 1, 0, 0, 1, 0, 1); expect_now("t4_r0",   2'b11, 2'b11, 1'b0, 1); tick();
        nop();                    expect_now("t4_r0sel", 2'b11, 2'b11, 1'b0, 1); tick();

        // r2 in both EX and MEM: youngest wins
        dec(2, 1, 0, 1, 1, 1, 1); expect_now("t4_w2a",  2'b11, 2'b11, 1'b0, 1); tick();
        dec(2, 1, 0, 1, 1, 1, 1); expect_now("t4_w2b",  2'b11, 2'b11, 1'b0, 1); tick();
        dec(9, 1, 0, 2, 1, 2, 1); expect_now("t4_r2",   2'b11, 2'b11, 1'b0, 1); tick();
        nop();                    expect_now("t4_young", 2'b01, 2'b01, 1'b0, 1); tick();

        // Load-use with hold: stall held 4 cycles, counted once
        dec(4, 1, 1, 1, 1, 0, 0); expect_now("t5_ld",   2'b11, 2'b11, 1'b0, 1); tick();
        bus.in_hold = 1'b1;
        dec(7, 1, 0, 4, 1, 4, 1);
        for (int i = 0; i < 3; i++) begin
            expect_now("t5_held", 2'b11, 2'b11, 1'b1, 1); tick();
        end
        bus.in_hold = 1'b0;
        expect_now("t5_stall4", 2'b11, 2'b11, 1'b1, 1); tick();
        expect_now("t5_reiss",  2'b11, 2'b11, 1'b0, 2); tick();
        nop();                    expect_now("t5_sel",  2'b00, 2'b00, 1'b0, 2); tick();

        // Load-use coinciding with flush: no stall, ADD squashed
        dec(4, 1, 1, 1, 1, 0, 0); expect_now("t5_ld2",  2'b11, 2'b11, 1'b0, 2); tick();
        bus.in_flush = 1'b1;
        dec(7, 1, 0, 4, 1, 4, 1); expect_now("t5_flush", 2'b11, 2'b11, 1'b0, 2); tick();
        bus.in_flush = 1'b0;
        dec(9, 1, 0, 7, 1, 7, 1); expect_now("t5_r7",   2'b11, 2'b11, 1'b0, 2); tick();
        nop();                    expect_now("t5_bubble", 2'b11, 2'b11, 1'b0, 2); tick();

        // Async reset while stalled with live selects
        dec(1, 1, 0, 2, 1, 2, 1); expect_now("t6_add",  2'b11, 2'b11, 1'b0, 2); tick();
        dec(4, 1, 1, 1, 1, 0, 0); expect_now("t6_ld",   2'b11, 2'b11, 1'b0, 2); tick();
        bus.in_hold = 1'b1;
        dec(7, 1, 0, 4, 1, 4, 1); expect_now("t6_pre",  2'b01, 2'b11, 1'b1, 2);
        @(negedge clk);
        #2;
        expect_now("t6_async", 2'b11, 2'b11, 1'b0, 0);
        rst = 1'b1;
        tick();
        bus.in_hold = 1'b0;
        nop();
        rst = 1'b0;
        expect_now("t6_after", 2'b11, 2'b11, 1'b0, 0); tick();

        // Counter saturation over many load-use events
        for (int i = 0; i < 20000; i++) begin
            dec(4, 1, 1, 1, 1, 0, 0); tick();
            dec(7, 1, 0, 4, 1, 4, 1); tick();
            tick();
        end
        nop(); expect_now("t6_sat", 2'b00, 2'b00, 1'b0, 255); tick();
        tick();
        tick();

        while (q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s never checked (cycle %0d)", q[0].name, q[0].cyc);
            void'(q.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
